// File: rtl/booth_pkg.sv
// booth_pkg: definitions shared by the Booth multiplier controller and the
// multiplier testbench.
//   MUL_WIDTH  operand width of the sequential Booth multiplier
//   MUL_ITERS  number of iteration cycles per multiplication
//   state_t    controller FSM state encoding (ST_* constants)
package booth_pkg;

  localparam int MUL_WIDTH = 32;
  localparam int MUL_ITERS = 32;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_CLR  = 3'd1;
  localparam state_t ST_LOAD = 3'd2;
  localparam state_t ST_RUN  = 3'd3;
  localparam state_t ST_CAP  = 3'd4;
  localparam state_t ST_DONE = 3'd5;

endpackage

// File: rtl/booth_operand_fifo.sv
// booth_operand_fifo: DEPTH x DATA_W synchronous FIFO holding operand pairs.
//   clk, reset         rising-edge clock, synchronous active-high reset
//   push, push_data    write request and data (ignored while full)
//   pop, pop_data      read request (ignored while empty) and head entry
//   full, empty        occupancy flags
// Push and pop in the same cycle leave the occupancy unchanged.
module booth_operand_fifo #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              push_ok;
  logic              pop_ok;

  assign full     = (cnt_q == CNT_W'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is not reset: a flushed buffer is empty by its counter.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/booth_mult_ctrl.sv
// booth_mult_ctrl: operand buffer and sequencer in front of the sequential
// Booth multiplier. One multiplication is in flight at a time.
//   clk, reset                  rising-edge clock, sync active-high reset
//   in_valid/in_ready/in_m/in_q operand pair handshake (2-deep buffer)
//   out_valid/out_ready/out_p   registered 2*WIDTH signed product handshake
//   busy                        FSM not idle
//   ops_done                    completed output handshakes (wraps)
//   mul_reset/mul_load          multiplier control
//   mul_M/mul_Q                 multiplier operands (current op)
//   mul_P                       multiplier product
module booth_mult_ctrl
  import booth_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [WIDTH-1:0]   in_m,
  input  logic signed [WIDTH-1:0]   in_q,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [2*WIDTH-1:0] out_p,
  output logic                      busy,
  output logic [15:0]               ops_done,
  output logic                      mul_reset,
  output logic                      mul_load,
  output logic signed [WIDTH-1:0]   mul_M,
  output logic signed [WIDTH-1:0]   mul_Q,
  input  logic signed [2*WIDTH-1:0] mul_P
);

  localparam int ITER_W = $clog2(MUL_ITERS);

  state_t                    state_q, state_d;
  logic [ITER_W-1:0]         iter_q, iter_d;
  logic signed [WIDTH-1:0]   op_m_q, op_m_d;
  logic signed [WIDTH-1:0]   op_q_q, op_q_d;
  logic signed [2*WIDTH-1:0] out_p_q, out_p_d;
  logic                      out_valid_q, out_valid_d;
  logic [15:0]               ops_done_q, ops_done_d;

  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      fifo_pop;
  logic [2*WIDTH-1:0]        fifo_head;

  booth_operand_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (2 * WIDTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (in_valid),
    .push_data ({in_m, in_q}),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    iter_d      = iter_q;
    op_m_d      = op_m_q;
    op_q_d      = op_q_q;
    out_p_d     = out_p_q;
    out_valid_d = out_valid_q;
    ops_done_d  = ops_done_q;
    fifo_pop    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ST_CLR;
        end
      end
      ST_CLR:  state_d = ST_LOAD;
      ST_LOAD: begin
        iter_d  = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        // Counter wraps back to 0 on the last iteration.
        iter_d = iter_q + 1'b1;
        if (iter_q == ITER_W'(MUL_ITERS - 1)) begin
          state_d = ST_CAP;
        end
      end
      ST_CAP: begin
        out_p_d     = mul_P;
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          ops_done_d  = ops_done_q + 1'b1;
          // Chain straight into the next operation when one is waiting.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = ST_CLR;
          end else begin
            state_d  = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (fifo_pop) begin
      op_m_d = fifo_head[2*WIDTH-1:WIDTH];
      op_q_d = fifo_head[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      iter_q      <= '0;
      op_m_q      <= '0;
      op_q_q      <= '0;
      out_p_q     <= '0;
      out_valid_q <= 1'b0;
      ops_done_q  <= '0;
    end else begin
      state_q     <= state_d;
      iter_q      <= iter_d;
      op_m_q      <= op_m_d;
      op_q_q      <= op_q_d;
      out_p_q     <= out_p_d;
      out_valid_q <= out_valid_d;
      ops_done_q  <= ops_done_d;
    end
  end

  assign in_ready  = !fifo_full;
  assign out_valid = out_valid_q;
  assign out_p     = out_p_q;
  assign busy      = (state_q != ST_IDLE);
  assign ops_done  = ops_done_q;
  // Multiplier is held cleared for as long as the controller is in reset.
  assign mul_reset = reset | (state_q == ST_CLR);
  assign mul_load  = (state_q == ST_LOAD);
  assign mul_M     = op_m_q;
  assign mul_Q     = op_q_q;

endmodule

// File: tb/tb_booth_mult_ctrl.sv
// tb_booth_mult_ctrl: directed-vector bench for booth_mult_ctrl. A small
// behavioural multiplier answers mul_reset/mul_load; expected products are
// hand-computed constants.
module tb_booth_mult_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_m;
  logic [31:0] in_q;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_p;
  logic        busy;
  logic [15:0] ops_done;
  logic        mul_reset;
  logic        mul_load;
  logic [31:0] mul_M;
  logic [31:0] mul_Q;
  logic [63:0] mul_P;

  int checks   = 0;
  int failures = 0;
  int n;

  logic signed [63:0] p_model;

  always #5 clk = ~clk;

  booth_mult_ctrl #(.WIDTH(32), .DEPTH(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_m      (in_m),
    .in_q      (in_q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .busy      (busy),
    .ops_done  (ops_done),
    .mul_reset (mul_reset),
    .mul_load  (mul_load),
    .mul_M     (mul_M),
    .mul_Q     (mul_Q),
    .mul_P     (mul_P)
  );

  // Behavioural stand-in for the Booth multiplier.
  always @(posedge clk) begin
    if (mul_reset) p_model <= '0;
    else if (mul_load)
      p_model <= $signed({{32{mul_M[31]}}, mul_M}) * $signed({{32{mul_Q[31]}}, mul_Q});
  end
  assign mul_P = p_model;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_one(input logic [31:0] m, input logic [31:0] q);
    @(negedge clk);
    in_valid = 1'b1;
    in_m     = m;
    in_q     = q;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!out_valid) chk("out_valid_timeout", 64'(out_valid), 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [31:0] m, input logic [31:0] q,
                        input logic [63:0] exp_p, input logic [15:0] exp_ops);
    int cyc;
    out_ready = 1'b1;
    push_one(m, q);
    wait_valid(cyc);
    chk({tag, "_latency"}, 64'(cyc), 64'd36);
    chk({tag, "_prod"}, out_p, exp_p);
    @(posedge clk);
    #1;
    chk({tag, "_vld_clr"}, 64'(out_valid), 64'd0);
    chk({tag, "_ops"}, 64'(ops_done), 64'(exp_ops));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_m      = '0;
    in_q      = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mul_reset", 64'(mul_reset), 64'd1);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_p", out_p, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ops", 64'(ops_done), 64'd0);
    chk("rst_mul_load", 64'(mul_load), 64'd0);
    chk("rst_mul_M", 64'(mul_M), 64'd0);
    chk("rst_mul_Q", 64'(mul_Q), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("idle_mul_reset", 64'(mul_reset), 64'd0);

    // Basic products
    run_op("p3x5", 32'd3, 32'd5, 64'h0000_0000_0000_000F, 16'd1);
    run_op("pm7x6", 32'hFFFF_FFF9, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6, 16'd2);
    run_op("pm1xm1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 16'd3);

    // Three back-to-back pairs with the consumer stalled
    out_ready = 1'b0;
    @(negedge clk); in_valid = 1'b1; in_m = 32'd2;          in_q = 32'd3;
    @(negedge clk);                  in_m = 32'hFFFF_FFFC;  in_q = 32'd5;
    @(negedge clk);                  in_m = 32'd100;        in_q = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    chk("b2b_full_ready", 64'(in_ready), 64'd0);
    @(negedge clk);                  in_m = 32'd7;          in_q = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(n);
    chk("b2b_a_latency", 64'(n), 64'd33);
    chk("b2b_a_prod", out_p, 64'd6);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("b2b_a_hold_p", out_p, 64'd6);
      chk("b2b_a_hold_v", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("b2b_a_taken", 64'(out_valid), 64'd0);
    wait_valid(n);
    chk("b2b_b_latency", 64'(n), 64'd35);
    chk("b2b_b_prod", out_p, 64'hFFFF_FFFF_FFFF_FFEC);
    @(posedge clk); #1;
    wait_valid(n);
    chk("b2b_c_gap", 64'(n + 1), 64'd36);
    chk("b2b_c_prod", out_p, 64'hFFFF_FFFF_FFFF_FF9C);
    @(posedge clk); #1;
    chk("b2b_ops", 64'(ops_done), 64'd6);
    chk("b2b_idle", 64'(busy), 64'd0);

    // Largest representable operands, consumer stalled for 10 cycles
    out_ready = 1'b0;
    push_one(32'h7FFF_FFFF, 32'h7FFF_FFFF);
    wait_valid(n);
    chk("max_prod", out_p, 64'h3FFF_FFFF_0000_0001);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("max_hold_p", out_p, 64'h3FFF_FFFF_0000_0001);
      chk("max_hold_busy", 64'(busy), 64'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("max_ops", 64'(ops_done), 64'd7);

    // Reset in the middle of RUN with a second pair buffered
    @(negedge clk); in_valid = 1'b1; in_m = 32'd9; in_q = 32'd9;
    @(negedge clk);                  in_m = 32'd5; in_q = 32'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("mid_iter", 64'(dut.iter_q), 64'd10);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_mul_reset", 64'(mul_reset), 64'd1);
    @(posedge clk); #1;
    chk("mid_out_valid", 64'(out_valid), 64'd0);
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_ops", 64'(ops_done), 64'd0);
    chk("mid_in_ready", 64'(in_ready), 64'd1);
    chk("mid_mul_M", 64'(mul_M), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_flushed", 64'(busy), 64'd0);
    run_op("p2x2", 32'd2, 32'd2, 64'd4, 16'd1);

    // ops_done wrap
    force dut.ops_done_q = 16'hFFFF;
    @(posedge clk); #1;
    release dut.ops_done_q;
    chk("wrap_preset", 64'(ops_done), 64'hFFFF);
    run_op("wrap", 32'd1, 32'd1, 64'd1, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
